game_access_ctrl: RTL and testbench

GAME_ACCESS_CTRL -- requirements
Module: game_access_ctrl

---
 rtl/game_access_ctrl_if.sv | 24 ++
 rtl/game_access_ctrl.sv | 126 ++++++++++++
 tb/tb_game_access_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/game_access_ctrl_if.sv
// Keypad/timebase inputs and datapath-control outputs of the game access controller.
// The master side drives keypad and tick; the slave side (the controller) drives the controls.
interface game_access_ctrl_if;
  logic       enter_pulse;
  logic [3:0] digit;
  logic       tick;
  logic       load_a;
  logic       load_b;
  logic       clear_ops;
  logic       adder_enable;
  logic       locked;
  logic [1:0] attempts_left;
  logic [2:0] state_code;

  modport master (
    output enter_pulse, digit, tick,
    input  load_a, load_b, clear_ops, adder_enable, locked, attempts_left, state_code
  );

  modport slave (
    input  enter_pulse, digit, tick,
    output load_a, load_b, clear_ops, adder_enable, locked, attempts_left, state_code
  );
endinterface

// File: rtl/game_access_ctrl.sv
// Passcode-gated access FSM with attempt lockout and session idle timeout.
// Load strobes are combinational; the state, the decodes and clear_ops come from registers.
module game_access_ctrl #(
  parameter logic [15:0] PASSCODE     = 16'h5293,
  parameter int          MAX_ATTEMPTS = 3,
  parameter int          LOCK_TICKS   = 8,
  parameter int          IDLE_TICKS   = 15
) (
  input  logic               clk,
  input  logic               rts,
  game_access_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    PASS   = 3'd0,
    LOCK   = 3'd1,
    LOAD_A = 3'd2,
    LOAD_B = 3'd3,
    SHOW   = 3'd4
  } state_t;

  localparam logic [1:0] ATT_MAX   = 2'(MAX_ATTEMPTS);
  localparam logic [7:0] LOCK_INIT = 8'(LOCK_TICKS);
  localparam logic [7:0] IDLE_LAST = 8'(IDLE_TICKS - 1);

  state_t     state;
  logic [1:0] idx;
  logic       mismatch;
  logic [1:0] attempts;
  logic [7:0] lock_cnt;
  logic [7:0] idle_cnt;
  logic       clear_q;

  logic [3:0] code_nib;
  logic       miss_now;

  always_comb begin
    code_nib = PASSCODE[15:12];
    case (idx)
      2'd1:    code_nib = PASSCODE[11:8];
      2'd2:    code_nib = PASSCODE[7:4];
      2'd3:    code_nib = PASSCODE[3:0];
      default: code_nib = PASSCODE[15:12];
    endcase
    miss_now = mismatch | (bus.digit != code_nib);
  end

  always_ff @(posedge clk or negedge rts) begin
    if (!rts) begin
      state    <= PASS;
      idx      <= 2'd0;
      mismatch <= 1'b0;
      attempts <= ATT_MAX;
      lock_cnt <= 8'd0;
      idle_cnt <= 8'd0;
      clear_q  <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      case (state)
        PASS: begin
          if (bus.enter_pulse) begin
            if (idx == 2'd3) begin
              idx      <= 2'd0;
              mismatch <= 1'b0;
              if (!miss_now) begin
                state    <= LOAD_A;
                attempts <= ATT_MAX;
                idle_cnt <= 8'd0;
              end else if (attempts <= 2'd1) begin
                attempts <= 2'd0;
                state    <= LOCK;
                lock_cnt <= LOCK_INIT;
              end else begin
                attempts <= attempts - 2'd1;
              end
            end else begin
              idx      <= idx + 2'd1;
              mismatch <= miss_now;
            end
          end
        end
        LOCK: begin
          // Keypad is dead here; only the timebase can release the lock.
          if (bus.tick) begin
            if (lock_cnt <= 8'd1) begin
              lock_cnt <= 8'd0;
              state    <= PASS;
              attempts <= ATT_MAX;
            end else begin
              lock_cnt <= lock_cnt - 8'd1;
            end
          end
        end
        LOAD_A, LOAD_B, SHOW: begin
          if (bus.enter_pulse) begin
            idle_cnt <= 8'd0;
            case (state)
              LOAD_A:  state <= LOAD_B;
              LOAD_B:  state <= SHOW;
              default: state <= LOAD_A;
            endcase
          end else if (bus.tick) begin
            // Count never passes IDLE_TICKS-1: the timeout fires on that tick.
            if (idle_cnt >= IDLE_LAST) begin
              idle_cnt <= 8'd0;
              state    <= PASS;
              clear_q  <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 8'd1;
            end
          end
        end
        default: state <= PASS;
      endcase
    end
  end

  assign bus.load_a        = bus.enter_pulse & (state == LOAD_A);
  assign bus.load_b        = bus.enter_pulse & (state == LOAD_B);
  assign bus.clear_ops     = clear_q;
  assign bus.adder_enable  = (state == LOAD_A) | (state == LOAD_B) | (state == SHOW);
  assign bus.locked        = (state == LOCK);
  assign bus.attempts_left = attempts;
  assign bus.state_code    = state;

endmodule

// File: tb/tb_game_access_ctrl.sv
// Directed vector bench for game_access_ctrl with default parameters.
module tb_game_access_ctrl;

  logic clk = 1'b0;
  logic rts = 1'b0;
  always #5 clk = ~clk;

  game_access_ctrl_if bus();

  game_access_ctrl dut (
    .clk (clk),
    .rts (rts),
    .bus (bus)
  );

  typedef struct {
    logic       rs;
    logic       en;
    logic [3:0] dg;
    logic       tk;
    logic [2:0] st;
    logic       ae;
    logic       lk;
    logic [1:0] at;
    logic       la;
    logic       lb;
    logic       co;
  } vec_t;

  vec_t tab[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(input int rs, input int en, input int dg, input int tk,
                              input int st, input int ae, input int lk, input int at,
                              input int la, input int lb, input int co);
    vec_t v;
    v.rs = 1'(rs); v.en = 1'(en); v.dg = 4'(dg); v.tk = 1'(tk);
    v.st = 3'(st); v.ae = 1'(ae); v.lk = 1'(lk); v.at = 2'(at);
    v.la = 1'(la); v.lb = 1'(lb); v.co = 1'(co);
    tab.push_back(v);
  endfunction

  // Four digit entries from PASS; the last one lands in st_f with attempts at_f.
  function automatic void add_code(input int d0, input int d1, input int d2, input int d3,
                                   input int at0, input int st_f, input int at_f);
    add(0, 1, d0, 0, 0, 0, 0, at0, 0, 0, 0);
    add(0, 1, d1, 0, 0, 0, 0, at0, 0, 0, 0);
    add(0, 1, d2, 0, 0, 0, 0, at0, 0, 0, 0);
    add(0, 1, d3, 0, st_f, (st_f >= 2) ? 1 : 0, (st_f == 1) ? 1 : 0, at_f, 0, 0, 0);
  endfunction

  task automatic apply(input vec_t v, input int i);
    logic [1:0] strb;
    logic [7:0] pre, act, exp;
    logic       ok;
    @(negedge clk);
    rts             = !v.rs;
    bus.enter_pulse = v.en;
    bus.digit       = v.dg;
    bus.tick        = v.tk;
    #1;
    exp  = {v.st, v.ae, v.lk, v.at, v.co};
    strb = {bus.load_a, bus.load_b};
    pre  = {bus.state_code, bus.adder_enable, bus.locked, bus.attempts_left, bus.clear_ops};
    ok   = (strb === {v.la, v.lb});
    if (v.rs) ok = ok && (pre === exp);
    @(posedge clk);
    #1;
    act = {bus.state_code, bus.adder_enable, bus.locked, bus.attempts_left, bus.clear_ops};
    n_vec++;
    if (!ok || act !== exp) begin
      n_bad++;
      $display("FAIL vec%0d: got ld_ab=%b pre=%b post{st,ae,lk,att,clr}=%b, want ld_ab=%b post=%b",
               i, strb, pre, act, {v.la, v.lb}, exp);
    end
  endtask

  initial begin
    bus.enter_pulse = 1'b0;
    bus.digit       = 4'd0;
    bus.tick        = 1'b0;

    // Reset with enter held: nothing may leak out.
    add(1, 1, 5, 0, 0, 0, 0, 3, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 3, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 3, 0, 0, 0);
    add_code(5, 2, 9, 3, 3, 2, 3);
    add(0, 0, 0, 1, 2, 1, 0, 3, 0, 0, 0);
    add(0, 1, 7, 0, 3, 1, 0, 3, 1, 0, 0);
    add(0, 1, 1, 0, 4, 1, 0, 3, 0, 1, 0);
    add(0, 1, 0, 0, 2, 1, 0, 3, 0, 0, 0);
    add(0, 1, 7, 0, 3, 1, 0, 3, 1, 0, 0);
    add(0, 1, 8, 0, 4, 1, 0, 3, 0, 1, 0);
    // Enter coincident with the 15th tick in SHOW wins over the timeout.
    for (int k = 0; k < 14; k++) add(0, 0, 0, 1, 4, 1, 0, 3, 0, 0, 0);
    add(0, 1, 2, 1, 2, 1, 0, 3, 0, 0, 0);
    for (int k = 0; k < 14; k++) add(0, 0, 0, 1, 2, 1, 0, 3, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 3, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
    // Timeout from SHOW.
    add_code(5, 2, 9, 3, 3, 2, 3);
    add(0, 1, 4, 0, 3, 1, 0, 3, 1, 0, 0);
    add(0, 1, 6, 0, 4, 1, 0, 3, 0, 1, 0);
    for (int k = 0; k < 14; k++) add(0, 0, 0, 1, 4, 1, 0, 3, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 3, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
    // Three failures (sticky first-digit miss, last-digit miss, out-of-code digit).
    add_code(6, 2, 9, 3, 3, 0, 2);
    add_code(5, 2, 9, 4, 2, 0, 1);
    add_code(5, 15, 9, 3, 1, 1, 0);
    add(0, 1, 5, 0, 1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 2, 0, 1, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) add(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 5, 1, 0, 0, 0, 3, 0, 0, 0);
    // Lock again, reset after 4 ticks, then a reset mid-entry.
    add_code(5, 2, 9, 4, 3, 0, 2);
    add_code(5, 2, 9, 4, 2, 0, 1);
    add_code(5, 2, 9, 4, 1, 1, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
    add(0, 1, 5, 0, 0, 0, 0, 3, 0, 0, 0);
    add(0, 1, 2, 0, 0, 0, 0, 3, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
    add_code(5, 2, 9, 3, 3, 2, 3);
    add(0, 0, 0, 0, 2, 1, 0, 3, 0, 0, 0);

    for (int i = 0; i < tab.size(); i++) apply(tab[i], i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
